// File: rtl/btn_event_pkg.sv
// Shared types and helpers for the button event controller.
// The optional BTN_EVT_AUTOREPEAT_EN build reuses these definitions unchanged.
package btn_event_pkg;

    localparam int EVT_W = 4;

    typedef struct packed {
        logic       is_release;
        logic [2:0] chan;
    } evt_word_t;

    function automatic int cycles_from_us(input int mhz, input int us);
        return mhz * us;
    endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Event word handshake between the button controller and its consumer.
interface btn_event_ctrl_if;
    import btn_event_pkg::*;

    logic      evt_valid;
    logic      evt_ready;
    evt_word_t evt_data;
    logic      evt_overflow;
    logic      ovf_clr;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_overflow,
        input  evt_ready,
        input  ovf_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_overflow,
        output evt_ready,
        output ovf_clr
    );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, debounce counter, level and edge pulses.
// With BTN_EVT_AUTOREPEAT_EN defined, also a per-channel auto-repeat down-counter.
module btn_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int RPT_DELAY  = 10,
    parameter int RPT_PERIOD = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic press_set,
    output logic release_set,
    output logic repeat_set
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES);
    localparam int              LAST_I   = DEB_CYCLES - 1;
    localparam logic [CNT_W:0]  CNT_LAST = LAST_I[CNT_W:0];

    logic             sync1;
    logic             sync2;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign s           = ACTIVE_LOW ? ~sync2 : sync2;
    // Extra headroom bit keeps the terminal compare free of wrap-around.
    assign flip        = (s != btn_level) && ({1'b0, cnt} == CNT_LAST);
    assign press_set   = flip && !btn_level;
    assign release_set = flip && btn_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= ACTIVE_LOW;
            sync2       <= ACTIVE_LOW;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            btn_press   <= press_set;
            btn_release <= release_set;
            if (flip) begin
                btn_level <= ~btn_level;
            end
            if (flip || (s == btn_level)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef BTN_EVT_AUTOREPEAT_EN
    localparam int RPT_MAX_I = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W     = $clog2(RPT_MAX_I + 1) + 1;
    localparam int DLY_I     = (RPT_DELAY >= 2) ? RPT_DELAY - 2 : 0;
    localparam int PER_I     = (RPT_PERIOD >= 1) ? RPT_PERIOD - 1 : 0;
    localparam logic [RPT_W-1:0] DLY_LD = DLY_I[RPT_W-1:0];
    localparam logic [RPT_W-1:0] PER_LD = PER_I[RPT_W-1:0];

    logic [RPT_W-1:0] rpt_cnt;

    // Loaded on the press edge so the first repeat word lands RPT_DELAY cycles after the level rises.
    assign repeat_set = btn_level && !flip && (rpt_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (flip) begin
            rpt_cnt <= btn_level ? '0 : DLY_LD;
        end else if (!btn_level) begin
            rpt_cnt <= '0;
        end else if (rpt_cnt == '0) begin
            rpt_cnt <= PER_LD;
        end else begin
            rpt_cnt <= rpt_cnt - 1'b1;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{RPT_DELAY, RPT_PERIOD};
    assign repeat_set = 1'b0;
`endif

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounced buttons plus a pending-event set drained through a valid/ready word port.
// Define BTN_EVT_AUTOREPEAT_EN to add held-button auto-repeat press events.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int CLOCK_FREQ_MHZ   = 12,
    parameter int CHANNELS         = 3,
    parameter int DEBOUNCE_US      = 10000,
    parameter bit ACTIVE_LOW       = 1'b0,
    parameter int REPEAT_DELAY_US  = 500000,
    parameter int REPEAT_PERIOD_US = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    btn_event_ctrl_if.master    evt
);

    localparam int DEB_CYCLES = cycles_from_us(CLOCK_FREQ_MHZ, DEBOUNCE_US);
    localparam int RPT_DELAY  = cycles_from_us(CLOCK_FREQ_MHZ, REPEAT_DELAY_US);
    localparam int RPT_PERIOD = cycles_from_us(CLOCK_FREQ_MHZ, REPEAT_PERIOD_US);
    localparam int NPEND      = 2 * CHANNELS;

    logic [CHANNELS-1:0] press_set;
    logic [CHANNELS-1:0] release_set;
    logic [CHANNELS-1:0] repeat_set;
    logic [NPEND-1:0]    set_v;
    logic [NPEND-1:0]    pend_q;
    logic [NPEND-1:0]    sel_oh;
    logic [NPEND-1:0]    clr_v;
    logic [3:0]          sel_idx;
    logic                load;
    logic                ovf_hit;
    logic                valid_q;
    evt_word_t           data_q;
    logic                ovf_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_deb (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[ch]),
            .btn_level   (btn_level[ch]),
            .btn_press   (btn_press[ch]),
            .btn_release (btn_release[ch]),
            .press_set   (press_set[ch]),
            .release_set (release_set[ch]),
            .repeat_set  (repeat_set[ch])
        );

        assign set_v[2*ch]   = press_set[ch] | repeat_set[ch];
        assign set_v[2*ch+1] = release_set[ch];
    end

    assign sel_oh = pend_q & (~pend_q + 1'b1);
    assign load   = (!valid_q || evt.evt_ready) && (|pend_q);
    assign clr_v  = load ? sel_oh : '0;
    // A bit leaving through the output register this edge is consumed, not lost.
    assign ovf_hit = |(set_v & pend_q & ~clr_v);

    always_comb begin
        sel_idx = '0;
        for (int i = NPEND - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~clr_v) | set_v;
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= '{is_release: sel_idx[0], chan: sel_idx[3:1]};
            end else if (evt.evt_ready) begin
                valid_q <= 1'b0;
            end
            ovf_q <= ovf_hit | (ovf_q & ~evt.ovf_clr);
        end
    end

    assign evt.evt_valid    = valid_q;
    assign evt.evt_data     = data_q;
    assign evt.evt_overflow = ovf_q;

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Input-conditioning stage upstream of cpu7_soc on the ice40 board. It synchronizes and debounces the board push-buttons and produces clean levels and one-cycle press/release pulses. It also queues press/release events behind a valid/ready handshake so a CPU core can consume them as input words. One instance per board top, fed directly from the BTNx pins.

Parameters:
CLOCK_FREQ_MHZ, 12, clk frequency in MHz
CHANNELS, 3, number of button inputs (1..8)
DEBOUNCE_US, 10000, required stable time in µs; DEBOUNCE_CYCLES = CLOCK_FREQ_MHZ*DEBOUNCE_US, which must be at least 2
ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; inversion applied after the synchronizer
REPEAT_DELAY_US, 500000, hold time before the first auto-repeat (used only with the optional feature)
REPEAT_PERIOD_US, 100000, spacing between auto-repeats (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
btn_raw  input  CHANNELS  asynchronous button pins
btn_level  output  CHANNELS  debounced pressed state, 1 = pressed
btn_press  output  CHANNELS  one-cycle pulse per debounced press
btn_release  output  CHANNELS  one-cycle pulse per debounced release
evt_valid  output  1  event word available
evt_ready  input  1  consumer accepts the word when valid&&ready
evt_data  output  4  {is_release, channel[2:0]}
evt_overflow  output  1  sticky: an event was lost
ovf_clr  input  1  clears evt_overflow

Behaviour:
- Reset (async assert, released on clk): btn_level, btn_press, btn_release, all pending bits, evt_valid, evt_data and evt_overflow are 0. Synchronizer flops reset to the inactive level, so no spurious event follows reset. Reset mid-bounce discards counter state.
- Synchronizer: two-flop chain per channel; polarity is normalized after it. The sync'd value (s) reaches the debouncer 2 cycles after the pin changes.
- Per-channel debouncer (counter CNT_W = $clog2(DEBOUNCE_CYCLES)):
  - While s == btn_level, the counter holds 0.
  - While s != btn_level, the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and s still differs, the next edge toggles btn_level, clears the counter and pulses btn_press or btn_release for exactly 1 cycle.
  - Any cycle with s == btn_level before the threshold restarts the count at 0, so glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Pin-to-level latency is 2 + DEBOUNCE_CYCLES cycles.
- Pending set: 2*CHANNELS bits, ordered {ch0 press, ch0 release, ch1 press, ...}. A bit is set on the same edge as its pulse.
  - If the bit is already set (unconsumed), it stays set and evt_overflow is set.
  - If a set and a load-clear hit the same bit on the same edge, the set wins.
- Output register:
  - Loads when !evt_valid || (evt_valid && evt_ready) and any pending bit is set.
  - Selection is the lowest-index pending bit. That bit is cleared and evt_valid goes to 1 on the following edge.
  - If nothing is pending, evt_valid drops after the handshake.
  - evt_data is stable while valid && !ready. One event per cycle is sustainable with ready held at 1.
  - Pending-to-valid latency is 1 cycle.
- evt_overflow: ovf_clr clears it; a simultaneous new overflow wins over the clear.
- Counter comparisons are done in CNT_W+1 bits, so there is no wrap-around.

Optional Feature:
BTN_EVT_AUTOREPEAT_EN
- Defined: each channel gets a repeat counter that is active while btn_level=1. After REPEAT_DELAY cycles it sets the press pending bit, then sets it again every REPEAT_PERIOD cycles.
  - btn_press does not pulse on repeats.
  - Repeats follow the normal overflow rules.
  - The repeat counter clears on release and on reset.
- Undefined: no repeat logic is generated; REPEAT_* parameters are ignored.

Decomposition:
- Package btn_event_pkg holds:
  - typedef evt_word_t packed struct {is_release, chan[2:0]};
  - localparam EVT_W = 4;
  - function cycles_from_us(mhz, us).
- Sub-module btn_debounce: one channel containing synchronizer, counter, level, press and release; instantiated with a generate loop.
- Pending set, priority select and output register live in btn_event_ctrl.

Test Plan (bench: CLOCK_FREQ_MHZ=1, DEBOUNCE_US=4, so 4 cycles; CHANNELS=3):
1. Clean press: btn_raw[1]=1 held.
   - btn_level[1] rises 6 cycles after the pin change, with a 1-cycle btn_press[1].
   - One cycle later evt_valid=1 with evt_data=4'b0001.
   - With ready=1, valid drops the cycle after the handshake.
2. Bounce: btn_raw[0] toggles 1,0,1 with 2-cycle widths, then holds 1.
   - Exactly one press on ch0, 6 cycles after the final rise.
   - No events before that.
3. Simultaneous: ch2 and ch0 pressed on the same cycle, ready=1.
   - evt_data sequence is 0000 then 0010 on consecutive cycles.
4. Backpressure/overflow: ready=0, ch0 press, release, press.
   - First word 0000 held stable; release pending.
   - Second press on an already-set bit sets evt_overflow=1.
   - ovf_clr clears it.
5. Reset mid-debounce: assert rst at count 2.
   - All outputs read 0 immediately.
   - After release with the pin still held, the press appears 6 cycles later.
6. With BTN_EVT_AUTOREPEAT_EN (REPEAT_DELAY_US=10, REPEAT_PERIOD_US=5): hold ch1.
   - Press words arrive at level+1, +10 and +15 cycles.
   - Releasing stops the repeats.
